mem_access_unit: RTL and testbench

Memory-stage access controller of the 5-stage MIPS32 pipeline. Consumes the 4-bit byte enable produced by the MEM-stage byte-enable logic, together with address, store data and load type. Runs a req/ack transaction on the data-memory bus, stalling the pipeline until the transaction completes. Returns the lane-extracted, sign- or zero-extended load result.

---
 rtl/mem_access_unit_pkg.sv | 19 +
 rtl/mem_access_unit_load_extender.sv | 37 +++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access path:
// load-type encodings, access FSM state type and the default ack timeout.
package mips_mem_pkg;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_BU = 3'b001;
    localparam logic [2:0] LD_B  = 3'b010;
    localparam logic [2:0] LD_HU = 3'b011;
    localparam logic [2:0] LD_H  = 3'b100;

    localparam int unsigned MAX_WAIT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mau_state_e;

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Picks the addressed byte/half lane out of a read word and sign- or
// zero-extends it; unknown load codes return the whole word.
module load_extender
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  a1_0_i,
    input  logic [2:0]  load_ext_i,
    output logic [31:0] ext_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (a1_0_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        // Halfwords use only Addr[1]; a misaligned Addr[0] is flagged upstream.
        half_sel = a1_0_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (load_ext_i)
            LD_W:    ext_data_o = rdata_i;
            LD_BU:   ext_data_o = {24'h000000, byte_sel};
            LD_B:    ext_data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_HU:   ext_data_o = {16'h0000, half_sel};
            LD_H:    ext_data_o = {{16{half_sel[15]}}, half_sel};
            default: ext_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: runs one req/ack bus transaction
// per load/store, stalls the pipeline meanwhile and returns the extended load.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [3:0]  BE,
    input  logic [31:0] WData,
    input  logic [2:0]  LoadExt,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] RData,
    output logic        AccessErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    mau_state_e  state_q;
    logic [7:0]  wait_cnt_q;
    logic [2:0]  ext_q;
    logic [1:0]  a1_0_q;
    logic        done_q;
    logic        err_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;

    logic [31:0] wdata_lane_d;
    logic [31:0] load_word_d;

    // Store data arrives in the low bytes; move it onto the addressed lanes.
    always_comb begin
        case (Addr[1:0])
            2'd0:    wdata_lane_d = WData;
            2'd1:    wdata_lane_d = {WData[23:0], 8'h00};
            2'd2:    wdata_lane_d = {WData[15:0], 16'h0000};
            default: wdata_lane_d = {WData[7:0], 24'h000000};
        endcase
    end

    load_extender u_load_extender (
        .rdata_i    (bus_rdata),
        .a1_0_i     (a1_0_q),
        .load_ext_i (ext_q),
        .ext_data_o (load_word_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 8'd0;
            ext_q       <= LD_W;
            a1_0_q      <= 2'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MemReq) begin
                        bus_addr_q  <= {Addr[31:2], 2'b00};
                        bus_be_q    <= BE;
                        bus_we_q    <= MemWrite;
                        bus_wdata_q <= wdata_lane_d;
                        ext_q       <= LoadExt;
                        a1_0_q      <= Addr[1:0];
                        bus_req_q   <= 1'b1;
                        wait_cnt_q  <= 8'd0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the timeout cycle still completes normally.
                    if (bus_ack) begin
                        if (!bus_we_q) begin
                            rdata_q <= load_word_d;
                        end
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (wait_cnt_q == MAX_WAIT_C) begin
                        rdata_q   <= 32'd0;
                        err_q     <= 1'b1;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Combinational so the pipeline freezes in the request cycle itself.
    assign Stall = !reset && ((state_q == IDLE && MemReq) || state_q == BUSY);

    assign Done      = done_q;
    assign AccessErr = err_q;
    assign RData     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level timing and
// data model; directed cases pin the model with literal values.
module tb_mem_access_unit;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [3:0]  BE;
    logic [31:0] WData;
    logic [2:0]  LoadExt;
    logic        Stall;
    logic        Done;
    logic [31:0] RData;
    logic        AccessErr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Current transaction as seen by the model
    bit          tr_active = 1'b0;
    int          tr_t;
    int          tr_k;
    bit          tr_err;
    logic [31:0] tr_addr;
    logic [3:0]  tr_be;
    bit          tr_we;
    logic [31:0] tr_wd;
    logic [31:0] tr_rd;
    logic [31:0] last_rd = 32'd0;
    int          stall_cnt;

    mem_access_unit #(.MAX_WAIT(MAXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemReq    (MemReq),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .BE        (BE),
        .WData     (WData),
        .LoadExt   (LoadExt),
        .Stall     (Stall),
        .Done      (Done),
        .RData     (RData),
        .AccessErr (AccessErr),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [31:0] rd, input logic [1:0] a,
                                              input logic [2:0] ext);
        longint b;
        longint h;
        b = (longint'(rd) >> (8 * int'(a))) % 256;
        h = (longint'(rd) >> (16 * int'(a[1]))) % 65536;
        case (ext)
            3'd1:    return 32'(b);
            3'd2:    return 32'((b >= 128) ? b - 256 : b);
            3'd3:    return 32'(h);
            3'd4:    return 32'((h >= 32768) ? h - 65536 : h);
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] a);
        longint w;
        w = longint'(wd) * (longint'(1) << (8 * int'(a)));
        return 32'(w % (longint'(1) << 32));
    endfunction

    // Per-cycle compare against the transaction timing rules
    always @(negedge clk) begin
        int  off;
        bit  e_stall, e_req, e_done, e_err, c_bus, c_rd;
        e_stall = 0; e_req = 0; e_done = 0; e_err = 0; c_bus = 0; c_rd = 0;
        if (tr_active) begin
            off = cyc - tr_t;
            if (off == 0) begin
                e_stall = 1;
            end else if (off >= 1 && off <= 1 + tr_k) begin
                e_stall = 1; e_req = 1; c_bus = 1;
            end else if (off == 2 + tr_k) begin
                e_done = 1; e_err = tr_err; c_rd = 1;
            end
        end
        if (Stall) stall_cnt++;
        check("Stall", 32'(Stall), 32'(e_stall));
        check("bus_req", 32'(bus_req), 32'(e_req));
        check("Done", 32'(Done), 32'(e_done));
        check("AccessErr", 32'(AccessErr), 32'(e_err));
        if (c_bus) begin
            check("bus_addr", bus_addr, {tr_addr[31:2], 2'b00});
            check("bus_be", 32'(bus_be), 32'(tr_be));
            check("bus_we", 32'(bus_we), 32'(tr_we));
            check("bus_wdata", bus_wdata, tr_wd);
        end
        if (c_rd) check("RData", RData, tr_rd);
    end

    // Drives one access starting in the next cycle; returns in its Done cycle
    // (or after the reset cycle when rst_at selects a busy cycle to reset in).
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input logic [2:0] ext,
                           input logic [31:0] rd, input int delay, input int rst_at);
        @(posedge clk); #1;
        MemReq = 1'b1; MemWrite = we; Addr = addr; BE = be; WData = wd; LoadExt = ext;
        bus_ack = 1'b0; bus_rdata = $urandom;
        tr_t = cyc; tr_err = (delay > MAXW); tr_k = tr_err ? MAXW : delay;
        tr_addr = addr; tr_be = be; tr_we = we; tr_wd = model_wdata(wd, addr[1:0]);
        tr_rd = tr_err ? 32'd0 : (we ? last_rd : model_ext(rd, addr[1:0], ext));
        stall_cnt = 0;
        tr_active = 1'b1;
        for (int j = 0; j <= tr_k; j++) begin
            @(posedge clk); #1;
            if (j == rst_at) begin
                reset = 1'b1; MemReq = 1'b0; bus_ack = 1'b0; tr_active = 1'b0;
                #1;
                check("rst_bus_req", 32'(bus_req), 32'd0);
                check("rst_Stall", 32'(Stall), 32'd0);
                check("rst_RData", RData, 32'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                last_rd = 32'd0;
                return;
            end
            bus_ack = (j == delay);
            bus_rdata = (j == delay) ? rd : $urandom;
        end
        @(posedge clk); #1;
        // Done cycle: ack and MemReq here must be ignored
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        MemReq = 1'($urandom_range(0, 1));
        last_rd = tr_rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            tr_active = 1'b0;
            MemReq = 1'b0;
            bus_ack = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Addr = '0; BE = '0; WData = '0;
        LoadExt = '0; bus_rdata = '0; bus_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_RData", RData, 32'd0);
        check("reset_bus_addr", bus_addr, 32'd0);
        check("reset_bus_wdata", bus_wdata, 32'd0);
        check("reset_bus_be", 32'(bus_be), 32'd0);
        check("reset_bus_we", 32'(bus_we), 32'd0);
        reset = 1'b0;
        idle(2);

        // sw, ack after 2 busy cycles
        run_txn(1'b1, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 3'd0, 32'h0, 2, -1);
        check("sw_model_wdata", tr_wd, 32'hDEAD_BEEF);
        check("sw_done_cycle", 32'(cyc - tr_t), 32'd4);
        check("sw_Done", 32'(Done), 32'd1);
        check("sw_stall_cycles", 32'(stall_cnt), 32'd4);
        idle(1);

        // sb to the top lane, immediate ack
        run_txn(1'b1, 32'h0000_2003, 4'b1000, 32'h0000_00A5, 3'd0, 32'h0, 0, -1);
        check("sb_model_wdata", tr_wd, 32'hA500_0000);
        check("sb_done_cycle", 32'(cyc - tr_t), 32'd2);
        check("sb_Done", 32'(Done), 32'd1);

        // lb / lbu / lh / lhu, back to back
        run_txn(1'b0, 32'h0000_3001, 4'b0010, 32'h0, 3'd2, 32'h1234_F600, 1, -1);
        check("lb_RData", RData, 32'hFFFF_FFF6);
        run_txn(1'b0, 32'h0000_3001, 4'b0010, 32'h0, 3'd1, 32'h1234_F600, 0, -1);
        check("lbu_RData", RData, 32'h0000_00F6);
        run_txn(1'b0, 32'h0000_3002, 4'b1100, 32'h0, 3'd4, 32'h8001_AAAA, 3, -1);
        check("lh_RData", RData, 32'hFFFF_8001);
        run_txn(1'b0, 32'h0000_3002, 4'b1100, 32'h0, 3'd3, 32'h8001_AAAA, 0, -1);
        check("lhu_RData", RData, 32'h0000_8001);

        // ack in the cycle the counter reaches the limit wins
        run_txn(1'b0, 32'h0000_4000, 4'b1111, 32'h0, 3'd0, 32'h1357_9BDF, MAXW, -1);
        check("lastack_RData", RData, 32'h1357_9BDF);
        check("lastack_AccessErr", 32'(AccessErr), 32'd0);
        idle(1);

        // timeout
        run_txn(1'b0, 32'h0000_5000, 4'b1111, 32'h0, 3'd0, 32'hFFFF_FFFF, MAXW + 3, -1);
        check("to_done_cycle", 32'(cyc - tr_t), 32'd6);
        check("to_AccessErr", 32'(AccessErr), 32'd1);
        check("to_Done", 32'(Done), 32'd1);
        check("to_RData", RData, 32'd0);
        check("to_bus_req", 32'(bus_req), 32'd0);
        idle(2);

        // reset mid-busy, then a normal access
        run_txn(1'b0, 32'h0000_6000, 4'b1111, 32'h0, 3'd0, 32'h1111_2222, 3, 1);
        idle(1);
        run_txn(1'b0, 32'h0000_6004, 4'b1111, 32'h0, 3'd0, 32'hCAFE_F00D, 1, -1);
        check("post_rst_RData", RData, 32'hCAFE_F00D);
        idle(1);

        // randomized accesses
        for (int n = 0; n < 300; n++) begin
            bit          we;
            logic [31:0] a, wd, rd;
            logic [3:0]  be;
            logic [2:0]  ext;
            int          dly, ra;
            we  = 1'($urandom_range(0, 1));
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            be  = 4'($urandom_range(0, 15));
            ext = 3'($urandom_range(0, 7));
            dly = $urandom_range(0, MAXW + 2);
            ra  = ($urandom_range(0, 19) == 0) ? 0 : -1;
            run_txn(we, a, be, wd, ext, rd, dly, ra);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
